// File: rtl/id_pkg.sv
// Shared decode constants and stall-cause encoding for the ID stage.
package id_pkg;

    localparam int unsigned INSTR_W            = 32;
    localparam int unsigned MULDIV_LAT_DEFAULT = 4;
    localparam int unsigned BUSY_W             = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [2:0] OP_STORE_HI = 3'b101;

    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_MFHI   = 6'b010000;
    localparam logic [5:0] FN_MFLO   = 6'b010010;
    localparam logic [3:0] FN_MULDIV_HI = 4'b0110;

    typedef enum logic [1:0] {
        STALL_NONE,
        STALL_LOAD_USE,
        STALL_BRANCH_OP,
        STALL_MULDIV
    } stall_cause_e;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Pipeline-side bundle for the ID stage: fetch in, hazard sources, ID results out.
interface id_stage_pipe_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) ();

    logic                      cpu_en;
    logic                      if_valid;
    logic [DATA_W-1:0]         if_pc_4;
    logic [id_pkg::INSTR_W-1:0] if_instruction;
    logic                      flush;

    logic                      wb_we;
    logic [REG_ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]         wb_data;

    logic                      ex_we;
    logic                      ex_is_load;
    logic [REG_ADDR_W-1:0]     ex_addr;
    logic [DATA_W-1:0]         ex_alu_out;

    logic                      mem_we;
    logic                      mem_is_load;
    logic [REG_ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]         mem_alu_out;
    logic [DATA_W-1:0]         mem_mem_data;

    logic                      id_valid;
    logic [DATA_W-1:0]         id_pc_4;
    logic [id_pkg::INSTR_W-1:0] id_instruction;
    logic [DATA_W-1:0]         rs_data;
    logic [DATA_W-1:0]         rt_data;
    logic                      stall;
    logic                      redirect;
    logic [DATA_W-1:0]         redirect_pc;
    logic [31:0]               stall_count;

    modport master (
        output cpu_en, if_valid, if_pc_4, if_instruction, flush,
               wb_we, wb_addr, wb_data,
               ex_we, ex_is_load, ex_addr, ex_alu_out,
               mem_we, mem_is_load, mem_addr, mem_alu_out, mem_mem_data,
        input  id_valid, id_pc_4, id_instruction, rs_data, rt_data,
               stall, redirect, redirect_pc, stall_count
    );

    modport slave (
        input  cpu_en, if_valid, if_pc_4, if_instruction, flush,
               wb_we, wb_addr, wb_data,
               ex_we, ex_is_load, ex_addr, ex_alu_out,
               mem_we, mem_is_load, mem_addr, mem_alu_out, mem_mem_data,
        output id_valid, id_pc_4, id_instruction, rs_data, rt_data,
               stall, redirect, redirect_pc, stall_count
    );

endinterface

// File: rtl/regfile_bypass.sv
// Register file with hardwired zero entry and same-cycle writeback bypass.
module regfile_bypass #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0]     rdata_a_c_o,
    output logic [DATA_W-1:0]     rdata_b_c_o
);

    localparam int unsigned NREGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Entry 0 reads as zero regardless of writes; a live write wins over the array.
    always_comb begin
        rdata_a_c_o = regs_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_c_o = '0;
        end else if (wr_en && (waddr_i == raddr_a_i)) begin
            rdata_a_c_o = wdata_i;
        end

        rdata_b_c_o = regs_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_c_o = '0;
        end else if (wr_en && (waddr_i == raddr_b_i)) begin
            rdata_b_c_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: IF/ID register, operand forwarding, hazard stalls,
// mult/div busy tracking and early branch/jump resolution.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    id_stage_pipe_if.slave  bus
);

    logic                  id_valid_q, id_valid_d;
    logic [DATA_W-1:0]     id_pc_4_q, id_pc_4_d;
    logic [INSTR_W-1:0]    id_instr_q, id_instr_d;
    logic [BUSY_W-1:0]     busy_q, busy_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;

    logic [5:0]            opcode, funct;
    logic [REG_ADDR_W-1:0] rs_addr, rt_addr;
    logic                  is_rtype, is_beq, is_bne, is_jmp, is_jr;
    logic                  is_muldiv, is_mfhilo, uses_rs, uses_rt;

    assign opcode    = id_instr_q[31:26];
    assign funct     = id_instr_q[5:0];
    assign rs_addr   = REG_ADDR_W'(id_instr_q[25:21]);
    assign rt_addr   = REG_ADDR_W'(id_instr_q[20:16]);
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_bne    = (opcode == OP_BNE);
    assign is_jmp    = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_jr     = is_rtype && (funct == FN_JR);
    assign is_muldiv = is_rtype && (funct[5:2] == FN_MULDIV_HI);
    assign is_mfhilo = is_rtype && ((funct == FN_MFHI) || (funct == FN_MFLO));
    // rt is a source only for R-type, branches and stores; otherwise it is a destination.
    assign uses_rs   = !is_jmp;
    assign uses_rt   = is_rtype || is_beq || is_bne || (opcode[5:3] == OP_STORE_HI);

    logic [DATA_W-1:0] rf_rs, rf_rt;

    regfile_bypass #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .we_i        (bus.cpu_en && bus.wb_we),
        .waddr_i     (bus.wb_addr),
        .wdata_i     (bus.wb_data),
        .raddr_a_i   (rs_addr),
        .raddr_b_i   (rt_addr),
        .rdata_a_c_o (rf_rs),
        .rdata_b_c_o (rf_rt)
    );

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

    assign ex_hit_rs  = bus.ex_we && (bus.ex_addr != '0) && (bus.ex_addr == rs_addr);
    assign ex_hit_rt  = bus.ex_we && (bus.ex_addr != '0) && (bus.ex_addr == rt_addr);
    assign mem_hit_rs = bus.mem_we && (bus.mem_addr != '0) && (bus.mem_addr == rs_addr);
    assign mem_hit_rt = bus.mem_we && (bus.mem_addr != '0) && (bus.mem_addr == rt_addr);

    logic [DATA_W-1:0] rs_val, rt_val;

    // Youngest producer wins; regfile already covers WB bypass and register 0.
    always_comb begin
        rs_val = rf_rs;
        if (ex_hit_rs && !bus.ex_is_load) begin
            rs_val = bus.ex_alu_out;
        end else if (mem_hit_rs) begin
            rs_val = bus.mem_is_load ? bus.mem_mem_data : bus.mem_alu_out;
        end

        rt_val = rf_rt;
        if (ex_hit_rt && !bus.ex_is_load) begin
            rt_val = bus.ex_alu_out;
        end else if (mem_hit_rt) begin
            rt_val = bus.mem_is_load ? bus.mem_mem_data : bus.mem_alu_out;
        end
    end

    stall_cause_e cause;
    logic         stall;
    logic         memld_rs, memld_rt;

    assign memld_rs = mem_hit_rs && bus.mem_is_load;
    assign memld_rt = mem_hit_rt && bus.mem_is_load;

    // Branches compare in ID, so any EX result or a pending MEM load must settle first.
    always_comb begin
        cause = STALL_NONE;
        if (bus.ex_is_load && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt))) begin
            cause = STALL_LOAD_USE;
        end else if (((is_beq || is_bne) && (ex_hit_rs || ex_hit_rt || memld_rs || memld_rt))
                     || (is_jr && (ex_hit_rs || memld_rs))) begin
            cause = STALL_BRANCH_OP;
        end else if ((busy_q != '0) && (is_muldiv || is_mfhilo)) begin
            cause = STALL_MULDIV;
        end
    end

    assign stall = id_valid_q && (cause != STALL_NONE);

    logic              taken;
    logic [DATA_W-1:0] br_target, j_target;

    assign taken     = is_jmp || is_jr || (is_beq && (rs_val == rt_val))
                       || (is_bne && (rs_val != rt_val));
    assign br_target = id_pc_4_q + {{(DATA_W-18){id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    assign j_target  = {id_pc_4_q[DATA_W-1:28], id_instr_q[25:0], 2'b00};

    always_comb begin
        id_valid_d  = id_valid_q;
        id_pc_4_d   = id_pc_4_q;
        id_instr_d  = id_instr_q;
        busy_d      = busy_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.cpu_en) begin
            if (bus.flush) begin
                id_valid_d = 1'b0;
                id_instr_d = '0;
            end else if (!stall) begin
                id_valid_d = bus.if_valid;
                id_pc_4_d  = bus.if_pc_4;
                id_instr_d = bus.if_instruction;
            end
            if (id_valid_q && !stall && is_muldiv) begin
                busy_d = BUSY_W'(MULDIV_LAT);
            end else if (busy_q != '0) begin
                busy_d = busy_q - BUSY_W'(1);
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            id_pc_4_q   <= '0;
            id_instr_q  <= '0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_pc_4_q   <= id_pc_4_d;
            id_instr_q  <= id_instr_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.id_valid       = id_valid_q;
    assign bus.id_pc_4        = id_pc_4_q;
    assign bus.id_instruction = id_instr_q;
    assign bus.rs_data        = rs_val;
    assign bus.rt_data        = rt_val;
    assign bus.stall          = stall;
    assign bus.redirect       = id_valid_q && !stall && !bus.flush && taken;
    assign bus.redirect_pc    = is_jr ? rs_val : (is_jmp ? j_target : br_target);
    assign bus.stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed scenarios plus randomized traffic checked against a behavioural ID-stage model.
module tb_id_stage_pipe;

    localparam int unsigned LAT = 4;

    localparam logic [31:0] ADD_3_2_4 = 32'h0044_1820;
    localparam logic [31:0] BEQ_5_6_8 = 32'h10A6_0008;
    localparam logic [31:0] MULT_1_2  = 32'h0022_0018;
    localparam logic [31:0] MFLO_1    = 32'h0000_0812;
    localparam logic [31:0] JR_8      = 32'h0100_0008;
    localparam logic [31:0] ADD_1_7_0 = 32'h00E0_0820;
    localparam logic [31:0] ADD_1_9_0 = 32'h0120_0820;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .MULDIV_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state and expected combinational outputs.
    logic [31:0] m_rf [32];
    bit          m_valid;
    logic [31:0] m_pc4, m_instr, m_count;
    int          m_busy;
    bit          e_stall, e_redirect, e_issue;
    logic [31:0] e_rs, e_rt, e_rpc;

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'h0;
        if (bus.ex_we && !bus.ex_is_load && int'(bus.ex_addr) == a) return bus.ex_alu_out;
        if (bus.mem_we && int'(bus.mem_addr) == a)
            return bus.mem_is_load ? bus.mem_mem_data : bus.mem_alu_out;
        if (bus.cpu_en && bus.wb_we && int'(bus.wb_addr) == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    task automatic model_eval();
        int op, fn, rs, rt, ex_dst, ex_ld, mem_ld;
        bit is_r, is_br, is_jump, is_jr, md, mfx, use_rs, use_rt, lu, bh, mh, taken;
        op = int'(m_instr[31:26]); fn = int'(m_instr[5:0]);
        rs = int'(m_instr[25:21]); rt = int'(m_instr[20:16]);
        e_rs = m_read(rs);
        e_rt = m_read(rt);
        is_r    = (op == 0);
        is_br   = (op == 4) || (op == 5);
        is_jump = (op == 2) || (op == 3);
        is_jr   = is_r && (fn == 8);
        md      = is_r && (fn >= 24) && (fn <= 27);
        mfx     = is_r && (fn == 16 || fn == 18);
        use_rs  = !is_jump;
        use_rt  = is_r || is_br || (op >= 40 && op <= 47);
        ex_dst  = (bus.ex_we && bus.ex_addr != 0) ? int'(bus.ex_addr) : -1;
        ex_ld   = bus.ex_is_load ? ex_dst : -1;
        mem_ld  = (bus.mem_we && bus.mem_is_load && bus.mem_addr != 0) ? int'(bus.mem_addr) : -1;
        lu = (use_rs && rs == ex_ld) || (use_rt && rt == ex_ld);
        bh = (is_br && (rs == ex_dst || rt == ex_dst || rs == mem_ld || rt == mem_ld))
             || (is_jr && (rs == ex_dst || rs == mem_ld));
        mh = (m_busy > 0) && (md || mfx);
        e_stall = m_valid && (lu || bh || mh);
        e_issue = m_valid && !e_stall && md;
        taken = is_jump || is_jr || (op == 4 && e_rs == e_rt) || (op == 5 && e_rs != e_rt);
        e_redirect = m_valid && !e_stall && !bus.flush && taken;
        if (is_jr) e_rpc = e_rs;
        else if (is_jump) e_rpc = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
        else e_rpc = m_pc4 + 32'(int'($signed(m_instr[15:0])) * 4);
    endtask

    task automatic model_clock();
        model_eval();
        if (rst) begin
            foreach (m_rf[i]) m_rf[i] = 32'h0;
            m_valid = 0; m_pc4 = 0; m_instr = 0; m_busy = 0; m_count = 0;
        end else if (bus.cpu_en) begin
            if (bus.wb_we && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
            if (e_issue) m_busy = LAT;
            else if (m_busy > 0) m_busy--;
            if (e_stall && m_count != 32'hFFFF_FFFF) m_count++;
            if (bus.flush) begin
                m_valid = 0; m_instr = 0;
            end else if (!e_stall) begin
                m_valid = bus.if_valid; m_pc4 = bus.if_pc_4; m_instr = bus.if_instruction;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_en = 1; bus.if_valid = 0; bus.if_pc_4 = 0; bus.if_instruction = 0; bus.flush = 0;
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.ex_we = 0; bus.ex_is_load = 0; bus.ex_addr = 0; bus.ex_alu_out = 0;
        bus.mem_we = 0; bus.mem_is_load = 0; bus.mem_addr = 0; bus.mem_alu_out = 0;
        bus.mem_mem_data = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        adv(); adv();
        rst = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] rs, rt, rd;
        rs = 32'($urandom_range(0, 7)); rt = 32'($urandom_range(0, 7));
        rd = 32'($urandom_range(0, 7));
        case ($urandom_range(0, 12))
            0:  return (rs << 21) | (rt << 16) | (rd << 11) | 32'd32;
            1:  return (rs << 21) | (rt << 16) | 32'd24;
            2:  return (rs << 21) | (rt << 16) | 32'd26;
            3:  return (rd << 11) | 32'd16;
            4:  return (rd << 11) | 32'd18;
            5:  return (rs << 21) | 32'd8;
            6:  return (32'd4 << 26) | (rs << 21) | (rt << 16) | 32'($urandom_range(0, 65535));
            7:  return (32'd5 << 26) | (rs << 21) | (rt << 16) | 32'($urandom_range(0, 65535));
            8:  return (32'd2 << 26) | ($urandom & 32'h03FF_FFFF);
            9:  return (32'd3 << 26) | ($urandom & 32'h03FF_FFFF);
            10: return (32'd35 << 26) | (rs << 21) | (rt << 16) | 32'($urandom_range(0, 255));
            11: return (32'd43 << 26) | (rs << 21) | (rt << 16) | 32'($urandom_range(0, 255));
            default: return (32'd8 << 26) | (rs << 21) | (rt << 16) | 32'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b exp 0", bus.id_valid); end
        checks++; if (bus.id_pc_4 !== 32'h0) begin errors++; $display("FAIL reset_id_pc_4 got %h exp 0", bus.id_pc_4); end
        checks++; if (bus.id_instruction !== 32'h0) begin errors++; $display("FAIL reset_id_instr got %h exp 0", bus.id_instruction); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b exp 0", bus.redirect); end
        checks++; if (bus.stall_count !== 32'h0) begin errors++; $display("FAIL reset_stall_count got %0d exp 0", bus.stall_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.if_valid = 1; bus.if_pc_4 = 32'h104; bus.if_instruction = ADD_3_2_4;
        adv();
        bus.if_valid = 0; bus.if_instruction = 0;
        bus.ex_we = 1; bus.ex_is_load = 1; bus.ex_addr = 5'd2; bus.ex_alu_out = 32'h999;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b exp 1", bus.stall); end
        adv();
        bus.ex_we = 0; bus.ex_is_load = 0;
        bus.mem_we = 1; bus.mem_is_load = 1; bus.mem_addr = 5'd2;
        bus.mem_mem_data = 32'h0000_00AB; bus.mem_alu_out = 32'h999;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_use_release got %b exp 0", bus.stall); end
        checks++; if (bus.rs_data !== 32'h0000_00AB) begin errors++; $display("FAIL load_use_rs got %h exp 000000ab", bus.rs_data); end
        checks++; if (bus.stall_count !== 32'd1) begin errors++; $display("FAIL load_use_count got %0d exp 1", bus.stall_count); end
        adv();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        bus.wb_we = 1; bus.wb_addr = 5'd6; bus.wb_data = 32'h10;
        bus.if_valid = 1; bus.if_pc_4 = 32'h100; bus.if_instruction = BEQ_5_6_8;
        adv();
        bus.wb_we = 0; bus.if_valid = 0; bus.if_instruction = 0;
        bus.ex_we = 1; bus.ex_is_load = 0; bus.ex_addr = 5'd5; bus.ex_alu_out = 32'h10;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL branch_stall got %b exp 1", bus.stall); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL branch_no_redirect got %b exp 0", bus.redirect); end
        adv();
        bus.ex_we = 0; bus.mem_we = 1; bus.mem_is_load = 0; bus.mem_addr = 5'd5; bus.mem_alu_out = 32'h10;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL branch_release got %b exp 0", bus.stall); end
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL branch_redirect got %b exp 1", bus.redirect); end
        checks++; if (bus.redirect_pc !== 32'h120) begin errors++; $display("FAIL branch_target got %h exp 00000120", bus.redirect_pc); end
        adv();
    endtask

    task automatic test_muldiv();
        do_reset();
        bus.if_valid = 1; bus.if_pc_4 = 32'h200; bus.if_instruction = MULT_1_2;
        adv();
        bus.if_pc_4 = 32'h204; bus.if_instruction = MFLO_1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mult_issue got %b exp 0", bus.stall); end
        adv();
        bus.if_valid = 0; bus.if_instruction = 0;
        for (int i = 0; i < int'(LAT); i++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mflo_busy_%0d got %b exp 1", i, bus.stall); end
            adv();
        end
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mflo_issue got %b exp 0", bus.stall); end
        adv();
        #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL mflo_left_id got %b exp 0", bus.id_valid); end
        checks++; if (bus.stall_count !== LAT) begin errors++; $display("FAIL mflo_count got %0d exp %0d", bus.stall_count, LAT); end
    endtask

    task automatic test_regfile_bypass();
        do_reset();
        bus.if_valid = 1; bus.if_pc_4 = 32'h300; bus.if_instruction = ADD_1_7_0;
        adv();
        bus.wb_we = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus.rt_data !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h exp 0", bus.rt_data); end
        adv();
        bus.wb_addr = 5'd7; bus.wb_data = 32'h1234;
        #1;
        checks++; if (bus.rt_data !== 32'h0) begin errors++; $display("FAIL r0_hold got %h exp 0", bus.rt_data); end
        checks++; if (bus.rs_data !== 32'h1234) begin errors++; $display("FAIL wb_bypass got %h exp 00001234", bus.rs_data); end
        adv();
        bus.wb_we = 0;
        #1;
        checks++; if (bus.rs_data !== 32'h1234) begin errors++; $display("FAIL wb_stored got %h exp 00001234", bus.rs_data); end
    endtask

    task automatic test_cpu_en();
        do_reset();
        bus.if_valid = 1; bus.if_pc_4 = 32'h500; bus.if_instruction = ADD_1_9_0;
        adv();
        bus.cpu_en = 0; bus.if_instruction = ADD_3_2_4;
        bus.wb_we = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h55;
        adv();
        bus.cpu_en = 1; bus.wb_we = 0;
        #1;
        checks++; if (bus.id_instruction !== ADD_1_9_0) begin errors++; $display("FAIL en_hold got %h exp %h", bus.id_instruction, ADD_1_9_0); end
        checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL en_no_write got %h exp 0", bus.rs_data); end
        adv();
    endtask

    task automatic test_flush_reset();
        do_reset();
        bus.wb_we = 1; bus.wb_addr = 5'd8; bus.wb_data = 32'h4000;
        bus.if_valid = 1; bus.if_pc_4 = 32'h400; bus.if_instruction = JR_8;
        adv();
        bus.wb_we = 0; bus.if_instruction = ADD_3_2_4;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL jr_redirect got %b exp 1", bus.redirect); end
        checks++; if (bus.redirect_pc !== 32'h4000) begin errors++; $display("FAIL jr_target got %h exp 00004000", bus.redirect_pc); end
        bus.flush = 1;
        #1;
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL flush_redirect got %b exp 0", bus.redirect); end
        adv();
        bus.flush = 0;
        #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.id_valid); end
        checks++; if (bus.id_instruction !== 32'h0) begin errors++; $display("FAIL flush_instr got %h exp 0", bus.id_instruction); end
        adv();
        bus.ex_we = 1; bus.ex_is_load = 1; bus.ex_addr = 5'd2;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %b exp 1", bus.stall); end
        rst = 1;
        adv();
        rst = 0; idle_inputs();
        #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.id_valid); end
        checks++; if (bus.id_pc_4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", bus.id_pc_4); end
        checks++; if (bus.id_instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.id_instruction); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b exp 0", bus.redirect); end
        checks++; if (bus.stall_count !== 32'h0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.stall_count); end
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.cpu_en = ($urandom_range(0, 7) != 0);
            bus.flush = ($urandom_range(0, 11) == 0);
            bus.if_valid = ($urandom_range(0, 3) != 0);
            bus.if_pc_4 = $urandom & 32'hFFFF_FFFC;
            bus.if_instruction = rand_instr();
            bus.wb_we = 1'($urandom_range(0, 1));
            bus.wb_addr = 5'($urandom_range(0, 7));
            bus.wb_data = 32'($urandom_range(0, 3));
            bus.ex_we = 1'($urandom_range(0, 1));
            bus.ex_is_load = ($urandom_range(0, 3) == 0);
            bus.ex_addr = 5'($urandom_range(0, 7));
            bus.ex_alu_out = 32'($urandom_range(0, 3));
            bus.mem_we = 1'($urandom_range(0, 1));
            bus.mem_is_load = ($urandom_range(0, 3) == 0);
            bus.mem_addr = 5'($urandom_range(0, 7));
            bus.mem_alu_out = 32'($urandom_range(0, 3));
            bus.mem_mem_data = 32'($urandom_range(0, 3));
            #1;
            model_eval();
            checks++; if (bus.id_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, bus.id_valid, m_valid); end
            checks++; if (bus.id_pc_4 !== m_pc4) begin errors++; $display("FAIL rand_pc4 cyc %0d got %h exp %h", c, bus.id_pc_4, m_pc4); end
            checks++; if (bus.id_instruction !== m_instr) begin errors++; $display("FAIL rand_instr cyc %0d got %h exp %h", c, bus.id_instruction, m_instr); end
            checks++; if (bus.stall !== e_stall) begin errors++; $display("FAIL rand_stall cyc %0d got %b exp %b", c, bus.stall, e_stall); end
            checks++; if (bus.rs_data !== e_rs) begin errors++; $display("FAIL rand_rs cyc %0d got %h exp %h", c, bus.rs_data, e_rs); end
            checks++; if (bus.rt_data !== e_rt) begin errors++; $display("FAIL rand_rt cyc %0d got %h exp %h", c, bus.rt_data, e_rt); end
            checks++; if (bus.redirect !== e_redirect) begin errors++; $display("FAIL rand_redirect cyc %0d got %b exp %b", c, bus.redirect, e_redirect); end
            if (e_redirect) begin
                checks++; if (bus.redirect_pc !== e_rpc) begin errors++; $display("FAIL rand_target cyc %0d got %h exp %h", c, bus.redirect_pc, e_rpc); end
            end
            checks++; if (bus.stall_count !== m_count) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, bus.stall_count, m_count); end
            adv();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        foreach (m_rf[i]) m_rf[i] = 32'h0;
        m_valid = 0; m_pc4 = 0; m_instr = 0; m_busy = 0; m_count = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_muldiv();
        test_regfile_bypass();
        test_cpu_en();
        test_flush_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
